mul_32_seq: RTL
===============

MUL_32_SEQ -- requirements
Module: mul_32_seq

Interface
REQ-001 Parameters: none; operand width fixed at 32 bits, product width fixed at 64 bits.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 clear  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled on a rising edge of clock only while idle.
REQ-005 multiplicand  input  32  signed two's-complement operand M.
REQ-006 multiplier  input  32  signed two's-complement operand Q.
REQ-007 busy  output  1  high while a multiplication is in progress.
REQ-008 done  output  1  one-cycle pulse marking a valid new product.
REQ-009 product  output  64  signed result {HI[63:32], LO[31:0]}, registered.

Function
REQ-010 The block SHALL compute product = M x Q as a full 64-bit signed two's-complement result; no truncation and no overflow flag.
REQ-011 The block SHALL use radix-4 Booth (bit-pair) recoding of Q and retire one digit per cycle, 16 digits total.
- Digit i comes from Q bits {2i+1, 2i, 2i-1}, with Q[-1] = 0.
- Digit set: {0, +M, +2M, -M, -2M}.
- The partial-product adder SHALL be at least 34 bits wide so that +/-2M sign-extends correctly.
REQ-012 FSM states SHALL be IDLE, CALC and DONE.
- IDLE -> CALC: start = 1 at an edge.
- CALC -> CALC: while the iteration count < 15.
- CALC -> DONE: at the edge that retires digit 15.
- DONE -> IDLE: at the next edge, unconditionally.
REQ-013 On the IDLE->CALC edge the block SHALL:
- latch M and Q into internal registers;
- clear the accumulator;
- load the 4-bit iteration counter with 0.
Operand inputs SHALL be ignored after this edge.
REQ-014 busy SHALL be 1 in CALC and DONE, and 0 in IDLE.
REQ-015 done SHALL be 1 only in DONE, for exactly one clock cycle.
REQ-016 product SHALL update only on the CALC->DONE edge and SHALL hold its value until the next CALC->DONE edge or until clear.
REQ-017 Latency: if start is sampled at edge E0, then product is valid and done = 1 during the cycle after edge E16; the block accepts the next start at edge E17 or later.
REQ-018 start asserted while busy = 1 SHALL be ignored: no restart, no operand re-latch, no effect on the result.
REQ-019 start held high continuously SHALL begin a new operation at every IDLE edge, giving back-to-back operations every 17 cycles.
REQ-020 Operands of zero, -1 and 0x80000000 (including 0x80000000 x 0x80000000) SHALL produce the exact mathematical 64-bit result, with no special-case fast path; latency is always 17 edges.
REQ-021 There is no divide-by-zero analogue; every operand pair is legal.

Reset
REQ-022 While clear = 1, regardless of clock, the block SHALL force:
- state = IDLE;
- busy = 0, done = 0, product = 64'h0;
- counter and accumulator = 0.
REQ-023 A clear asserted mid-operation SHALL abort it; no done pulse and no product update SHALL occur for the aborted operation.
REQ-024 After clear deasserts, the first start sampled SHALL behave per REQ-013 and REQ-017.

Verification
REQ-025 M=7, Q=6, start pulsed at E0 -> busy=1 from E0; product=64'h000000000000002A with done=1 in the cycle after E16; busy=0 after E17.
REQ-026 Signed cases, each checked at done:
- M=-5, Q=3 -> 64'hFFFFFFFFFFFFFFF1;
- M=-1, Q=-1 -> 64'h0000000000000001;
- M=0x80000000, Q=0x80000000 -> 64'h4000000000000000;
- M=0x7FFFFFFF, Q=0x80000000 -> 64'hC000000080000000.
REQ-027 Start M=3, Q=4, then pulse start with M=9, Q=9 at E5 -> product=64'hC at E16, exactly one done pulse, second request ignored.
REQ-028 Start M=2, Q=2, assert clear asynchronously at mid-cycle 8 -> busy, done and product go 0 immediately; no done pulse afterwards.
REQ-029 start held high with the operand stream (1,1), (2,3) -> done pulses 17 cycles apart with products 1 then 6.
REQ-030 Randomised 10,000 signed operand pairs -> product equals a 64-bit signed reference model at every done pulse.

Source files
------------

// File: rtl/mul_32_seq.sv
// mul_32_seq: sequential 32x32 signed multiplier using radix-4 Booth recoding.
// One Booth digit is retired per clock, and 16 digits make up a full 64-bit
// product. When start is sampled at edge E0, done pulses and the new product
// is valid in the cycle after edge E16. The block is back in IDLE after E17.
//
// Ports:
//   clock        - single clock, rising-edge active
//   clear        - asynchronous active-high reset
//   start        - begin a multiplication (sampled only while idle)
//   multiplicand - signed operand M
//   multiplier   - signed operand Q
//   busy         - high while an operation is in progress (CALC and DONE)
//   done         - one-cycle pulse, high while a new product is valid
//   product      - registered signed 64-bit result, held between operations
module mul_32_seq (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [31:0] m_reg;
  logic [33:0] acc;
  logic [31:0] q_reg;
  logic        q_prev;
  logic [3:0]  count;

  logic [33:0] m_ext;
  logic [33:0] pp;
  logic [33:0] sum;
  logic [33:0] acc_next;
  logic [31:0] q_next;

  // Booth step. {acc, q_reg} is a shift register. The upper 34 bits hold the
  // running partial sum, and the low bits shift Q out two bits at a time.
  // The adder is 34 bits wide so that +/-2M (up to 2^32 in magnitude) still
  // sign-extends correctly. After the add, the concatenation is shifted
  // arithmetically right by two. Product bits therefore migrate into q_reg,
  // and after 16 steps q_reg holds LO and acc[31:0] holds HI.
  always_comb begin
    m_ext = {{2{m_reg[31]}}, m_reg};
    case ({q_reg[1:0], q_prev})
      3'b001, 3'b010: pp = m_ext;
      3'b011:         pp = m_ext << 1;
      3'b100:         pp = -(m_ext << 1);
      3'b101, 3'b110: pp = -m_ext;
      default:        pp = '0;
    endcase
    sum      = acc + pp;
    acc_next = {{2{sum[33]}}, sum[33:2]};
    q_next   = {sum[1:0], q_reg[31:2]};
  end

  // Control and datapath registers. Operands are captured only on the
  // IDLE->CALC edge, so start or operand changes during busy have no effect.
  // The product register is written only when the last digit retires. As a
  // result, an operation aborted by clear never disturbs it.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state   <= IDLE;
      m_reg   <= '0;
      acc     <= '0;
      q_reg   <= '0;
      q_prev  <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_reg  <= multiplicand;
            q_reg  <= multiplier;
            q_prev <= 1'b0;
            acc    <= '0;
            count  <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_next;
          q_reg  <= q_next;
          q_prev <= q_reg[1];
          count  <= count + 4'd1;
          if (count == 4'd15) begin
            product <= {acc_next[31:0], q_next};
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
